// File: rtl/dma_bench_status_pkg.sv
// Shared definitions for the board-status LED stage: status state encodings
// and the LED pattern each state drives.
package dma_bench_status_pkg;

   typedef enum logic [1:0] {
      LINK_DOWN   = 2'd0,
      OK          = 2'd1,
      COR_WARN    = 2'd2,
      UNCOR_FAULT = 2'd3
   } status_state_e;

   // Status LED pattern; a blinking yellow follows the shared blink phase.
   typedef struct packed {
      logic green;
      logic yellow;
      logic yellow_blink;
   } led_map_t;

   localparam led_map_t LED_MAP_LINK_DOWN   = '{green: 1'b0, yellow: 1'b0, yellow_blink: 1'b0};
   localparam led_map_t LED_MAP_OK          = '{green: 1'b1, yellow: 1'b0, yellow_blink: 1'b0};
   localparam led_map_t LED_MAP_COR_WARN    = '{green: 1'b1, yellow: 1'b1, yellow_blink: 1'b0};
   localparam led_map_t LED_MAP_UNCOR_FAULT = '{green: 1'b0, yellow: 1'b0, yellow_blink: 1'b1};

   function automatic led_map_t led_for_state(input status_state_e state);
      led_map_t map;
      case (state)
         LINK_DOWN:   map = LED_MAP_LINK_DOWN;
         OK:          map = LED_MAP_OK;
         COR_WARN:    map = LED_MAP_COR_WARN;
         UNCOR_FAULT: map = LED_MAP_UNCOR_FAULT;
         default:     map = LED_MAP_LINK_DOWN;
      endcase
      return map;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Millisecond-scale prescaler plus the blink phase shared by all LEDs.
// tick is high for one clk when the prescaler sits at TICK_DIV-1; phase
// toggles once every BLINK_TICKS ticks.
module led_tick_gen #(
   parameter int TICK_DIV    = 250000,
   parameter int BLINK_TICKS = 250
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic phase
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   logic [TW-1:0] div_q;
   logic [BW-1:0] blink_q;
   logic          phase_q;

   assign tick  = (div_q == TICK_LAST);
   assign phase = phase_q;

   // Prescaler wraps on tick; blink counter advances once per tick.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
      end else begin
         div_q <= tick ? '0 : div_q + 1'b1;
         if (tick) begin
            if (blink_q == BLINK_LAST) begin
               blink_q <= '0;
               phase_q <= ~phase_q;
            end else begin
               blink_q <= blink_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pcie_status_led.sv
// QSFP-cage LED driver downstream of the DMA benchmark core: activity LED,
// green/yellow status LEDs from a link/error FSM, and saturating error
// counters. Inputs update internal state on one edge; the registered outputs
// follow on the next edge.
module pcie_status_led
   import dma_bench_status_pkg::*;
#(
   parameter int TICK_DIV       = 250000,
   parameter int ACT_HOLD_TICKS = 50,
   parameter int BLINK_TICKS    = 250,
   parameter int ERR_HOLD_TICKS = 1000,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 link_up,
   input  logic                 rq_beat,
   input  logic                 rc_beat,
   input  logic                 status_error_cor,
   input  logic                 status_error_uncor,
   input  logic                 clear,
   output logic                 qsfp_led_act,
   output logic                 qsfp_led_stat_g,
   output logic                 qsfp_led_stat_y,
   output logic [CNT_WIDTH-1:0] err_cor_count,
   output logic [CNT_WIDTH-1:0] err_uncor_count,
   output logic                 fault
);

   localparam int AW = $clog2(ACT_HOLD_TICKS + 1);
   localparam int EW = $clog2(ERR_HOLD_TICKS + 1);
   localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_HOLD_TICKS);
   localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_HOLD_TICKS);

   logic                 tick;
   logic                 phase;
   logic                 link_q;
   logic [AW-1:0]        act_timer_q, act_timer_d;
   logic [EW-1:0]        err_timer_q, err_timer_d;
   status_state_e        state_q, state_d;
   logic [CNT_WIDTH-1:0] cor_cnt_q, cor_cnt_d;
   logic [CNT_WIDTH-1:0] uncor_cnt_q, uncor_cnt_d;
   led_map_t             led_map;

   led_tick_gen #(
      .TICK_DIV    (TICK_DIV),
      .BLINK_TICKS (BLINK_TICKS)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .phase (phase)
   );

   // Activity hold timer: any beat reloads, otherwise count down per tick.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      act_timer_d = act_timer_q;
      if (rq_beat || rc_beat) begin
         act_timer_d = ACT_LOAD;
      end else if (tick && (act_timer_q != '0)) begin
         act_timer_d = act_timer_q - 1'b1;
      end
   end

   // Status next-state; uncorrectable errors override every other event.
   always_comb begin
      state_d     = state_q;
      err_timer_d = (tick && (err_timer_q != '0)) ? err_timer_q - 1'b1 : err_timer_q;
      if (status_error_uncor) begin
         state_d = UNCOR_FAULT;
      end else begin
         case (state_q)
            UNCOR_FAULT: if (clear) state_d = link_up ? OK : LINK_DOWN;
            LINK_DOWN:   if (link_up) state_d = OK;
            OK: begin
               if (!link_up) begin
                  state_d = LINK_DOWN;
               end else if (status_error_cor) begin
                  state_d     = COR_WARN;
                  err_timer_d = ERR_LOAD;
               end
            end
            COR_WARN: begin
               if (!link_up) begin
                  state_d = LINK_DOWN;
               end else if (status_error_cor) begin
                  err_timer_d = ERR_LOAD;
               end else if (tick && (err_timer_q == EW'(1))) begin
                  state_d = OK;
               end
            end
            default: state_d = LINK_DOWN;
         endcase
      end
   end

   // Saturating error counters; clear restarts them at the same-cycle pulse.
   always_comb begin
      cor_cnt_d   = cor_cnt_q;
      uncor_cnt_d = uncor_cnt_q;
      if (clear) begin
         cor_cnt_d   = CNT_WIDTH'(status_error_cor);
         uncor_cnt_d = CNT_WIDTH'(status_error_uncor);
      end else begin
         if (status_error_cor && (cor_cnt_q != '1))     cor_cnt_d   = cor_cnt_q + 1'b1;
         if (status_error_uncor && (uncor_cnt_q != '1)) uncor_cnt_d = uncor_cnt_q + 1'b1;
      end
   end

   // Internal state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_q      <= 1'b0;
         act_timer_q <= '0;
         err_timer_q <= '0;
         state_q     <= LINK_DOWN;
         cor_cnt_q   <= '0;
         uncor_cnt_q <= '0;
      end else begin
         link_q      <= link_up;
         act_timer_q <= act_timer_d;
         err_timer_q <= err_timer_d;
         state_q     <= state_d;
         cor_cnt_q   <= cor_cnt_d;
         uncor_cnt_q <= uncor_cnt_d;
      end
   end

   assign led_map = led_for_state(state_q);

   // Output registers decoded from the internal state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qsfp_led_act    <= 1'b0;
         qsfp_led_stat_g <= 1'b0;
         qsfp_led_stat_y <= 1'b0;
         err_cor_count   <= '0;
         err_uncor_count <= '0;
         fault           <= 1'b0;
      end else begin
         qsfp_led_act    <= link_q & ((act_timer_q != '0) ? phase : 1'b1);
         qsfp_led_stat_g <= led_map.green;
         qsfp_led_stat_y <= led_map.yellow | (led_map.yellow_blink & phase);
         err_cor_count   <= cor_cnt_q;
         err_uncor_count <= uncor_cnt_q;
         fault           <= (state_q == UNCOR_FAULT);
      end
   end

endmodule

// File: tb/tb_pcie_status_led.sv
// Self-checking bench for pcie_status_led. An event-level model (tick and
// beat/error timestamps, sticky flags) predicts every output each cycle;
// hand-computed literals pin key points of the directed scenario.
module tb_pcie_status_led;

   localparam int TICK_DIV       = 4;
   localparam int ACT_HOLD_TICKS = 3;
   localparam int BLINK_TICKS    = 2;
   localparam int ERR_HOLD_TICKS = 5;
   localparam int CNT_WIDTH      = 4;
   localparam int CNT_MAX        = 15;

   logic clk = 1'b0;
   logic rst_n;
   logic link_up, rq_beat, rc_beat, cor, uncor, clr;
   logic act, stat_g, stat_y, flt;
   logic [CNT_WIDTH-1:0] cor_count, uncor_count;

   int n_total = 0;
   int n_bad   = 0;
   bit cmp_on  = 1'b0;

   always #5 clk = ~clk;

   pcie_status_led #(
      .TICK_DIV       (TICK_DIV),
      .ACT_HOLD_TICKS (ACT_HOLD_TICKS),
      .BLINK_TICKS    (BLINK_TICKS),
      .ERR_HOLD_TICKS (ERR_HOLD_TICKS),
      .CNT_WIDTH      (CNT_WIDTH)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .link_up            (link_up),
      .rq_beat            (rq_beat),
      .rc_beat            (rc_beat),
      .status_error_cor   (cor),
      .status_error_uncor (uncor),
      .clear              (clr),
      .qsfp_led_act       (act),
      .qsfp_led_stat_g    (stat_g),
      .qsfp_led_stat_y    (stat_y),
      .err_cor_count      (cor_count),
      .err_uncor_count    (uncor_count),
      .fault              (flt)
   );

   // Model state: edge count, ticks elapsed, and the tick count at which the
   // last beat / last correctable warning started.
   typedef struct packed {
      int k;
      int ticks;
      bit link_reg;
      bit up;
      bit fault;
      bit warn;
      int warn_mark;
      bit beat_seen;
      int beat_mark;
      int cor_cnt;
      int uncor_cnt;
   } model_t;

   typedef struct packed {
      logic act;
      logic g;
      logic y;
      logic flt;
      logic [CNT_WIDTH-1:0] cor;
      logic [CNT_WIDTH-1:0] uncor;
   } exp_t;

   model_t m_q;
   exp_t   exp_q;

   function automatic int sat_add(input int cnt, input bit pulse, input bit clear_now);
      if (clear_now) return int'(pulse);
      return (cnt + int'(pulse) > CNT_MAX) ? CNT_MAX : cnt + int'(pulse);
   endfunction

   function automatic model_t m_step(input model_t m, input bit link, input bit beat,
                                     input bit c, input bit u, input bit cl);
      model_t n;
      n = m;
      if (m.k % TICK_DIV == TICK_DIV - 1) n.ticks = m.ticks + 1;
      n.k        = m.k + 1;
      n.link_reg = link;
      if (beat) begin
         n.beat_seen = 1'b1;
         n.beat_mark = n.ticks;
      end
      if (u) begin
         n.fault = 1'b1;
         n.warn  = 1'b0;
      end else if (m.fault) begin
         if (cl) begin
            n.fault = 1'b0;
            n.up    = link;
            n.warn  = 1'b0;
         end
      end else if (!m.up) begin
         if (link) n.up = 1'b1;
      end else if (!link) begin
         n.up   = 1'b0;
         n.warn = 1'b0;
      end else if (c) begin
         n.warn      = 1'b1;
         n.warn_mark = n.ticks;
      end
      n.cor_cnt   = sat_add(m.cor_cnt, c, cl);
      n.uncor_cnt = sat_add(m.uncor_cnt, u, cl);
      return n;
   endfunction

   function automatic exp_t m_out(input model_t m);
      exp_t e;
      bit ph;
      bit busy;
      bit warn_live;
      ph        = ((m.ticks / BLINK_TICKS) % 2) == 1;
      busy      = m.beat_seen && (m.ticks - m.beat_mark < ACT_HOLD_TICKS);
      warn_live = m.warn && (m.ticks - m.warn_mark < ERR_HOLD_TICKS);
      e.act     = m.link_reg ? (busy ? ph : 1'b1) : 1'b0;
      if (m.fault) begin
         e.g = 1'b0; e.y = ph;
      end else if (!m.up) begin
         e.g = 1'b0; e.y = 1'b0;
      end else begin
         e.g = 1'b1; e.y = warn_live;
      end
      e.flt   = m.fault;
      e.cor   = CNT_WIDTH'(m.cor_cnt);
      e.uncor = CNT_WIDTH'(m.uncor_cnt);
      return e;
   endfunction

   // Model advance: expectation for the next output update comes from the
   // pre-edge model state, then the model absorbs this edge's inputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q   <= '0;
         exp_q <= '0;
      end else begin
         exp_q <= m_out(m_q);
         m_q   <= m_step(m_q, link_up, rq_beat | rc_beat, cor, uncor, clr);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && cmp_on) begin
         check("act", 32'(act), 32'(exp_q.act));
         check("stat_g", 32'(stat_g), 32'(exp_q.g));
         check("stat_y", 32'(stat_y), 32'(exp_q.y));
         check("fault", 32'(flt), 32'(exp_q.flt));
         check("cor_count", 32'(cor_count), 32'(exp_q.cor));
         check("uncor_count", 32'(uncor_count), 32'(exp_q.uncor));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_act"}, 32'(act), 0);
      check({tag, "_g"}, 32'(stat_g), 0);
      check({tag, "_y"}, 32'(stat_y), 0);
      check({tag, "_fault"}, 32'(flt), 0);
      check({tag, "_cor"}, 32'(cor_count), 0);
      check({tag, "_uncor"}, 32'(uncor_count), 0);
   endtask

   initial begin
      rst_n = 1'b0; link_up = 1'b0; rq_beat = 1'b0; rc_beat = 1'b0;
      cor = 1'b0; uncor = 1'b0; clr = 1'b0;
      cyc(3);
      check_all_zero("reset");
      rst_n  = 1'b1;
      cmp_on = 1'b1;
      cyc(3);

      // Link comes up: one cycle of latency after it is sampled.
      link_up = 1'b1;
      cyc(1);
      check("link_latency_g", 32'(stat_g), 0);
      cyc(1);
      check("link_up_g", 32'(stat_g), 1);
      check("link_up_act", 32'(act), 1);
      check("link_up_y", 32'(stat_y), 0);
      cyc(5);

      // Single beat, then a burst of consecutive beats on both channels.
      rq_beat = 1'b1; cyc(1); rq_beat = 1'b0;
      cyc(30);
      check("act_idle_after_hold", 32'(act), 1);
      rq_beat = 1'b1; rc_beat = 1'b1; cyc(2); rq_beat = 1'b0;
      cyc(3); rc_beat = 1'b0;
      cyc(20);

      // Correctable error, then a reload before expiry.
      cor = 1'b1; cyc(1); cor = 1'b0;
      cyc(1);
      check("cor_warn_y", 32'(stat_y), 1);
      check("cor_warn_g", 32'(stat_g), 1);
      check("cor_count_1", 32'(cor_count), 1);
      cyc(10);
      cor = 1'b1; cyc(1); cor = 1'b0;
      cyc(14);
      check("cor_warn_extended", 32'(stat_y), 1);
      cyc(10);
      check("cor_warn_expired", 32'(stat_y), 0);
      check("cor_count_2", 32'(cor_count), 2);

      // Back-to-back pulses saturate the counter.
      cor = 1'b1; cyc(17); cor = 1'b0;
      cyc(2);
      check("cor_saturate", 32'(cor_count), 15);

      // Uncorrectable error is sticky through link loss.
      uncor = 1'b1; cyc(1); uncor = 1'b0;
      cyc(1);
      check("uncor_fault", 32'(flt), 1);
      check("uncor_g", 32'(stat_g), 0);
      check("uncor_count_1", 32'(uncor_count), 1);
      link_up = 1'b0;
      cyc(20);
      check("fault_holds_link_down", 32'(flt), 1);

      // Clear with link down releases to LINK_DOWN and zeroes counts.
      clr = 1'b1; cyc(1); clr = 1'b0;
      cyc(1);
      check_all_zero("clear_link_down");

      // Clear coinciding with uncor keeps the fault; count restarts at 1.
      link_up = 1'b1;
      cyc(3);
      uncor = 1'b1; cyc(1); uncor = 1'b0;
      cyc(2);
      clr = 1'b1; uncor = 1'b1; cyc(1); clr = 1'b0; uncor = 1'b0;
      cyc(1);
      check("clear_uncor_fault", 32'(flt), 1);
      check("clear_uncor_count", 32'(uncor_count), 1);

      // Clear coinciding with cor: fault released to OK, cor count = 1.
      clr = 1'b1; cor = 1'b1; cyc(1); clr = 1'b0; cor = 1'b0;
      cyc(1);
      check("clear_cor_fault", 32'(flt), 0);
      check("clear_cor_g", 32'(stat_g), 1);
      check("clear_cor_y", 32'(stat_y), 0);
      check("clear_cor_count", 32'(cor_count), 1);
      check("clear_cor_uncor", 32'(uncor_count), 0);
      cyc(30);

      // Asynchronous reset mid-operation.
      cor = 1'b1; cyc(1); cor = 1'b0;
      cyc(3);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(5);
      check("post_reset_g", 32'(stat_g), 1);
      check("post_reset_act", 32'(act), 1);
      cyc(5);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pcie_status_led.md
# pcie_status_led

Board-status indicator stage that sits directly downstream of the DMA benchmark core on the AU50. It consumes the core's PCIe error pulses, RQ/RC beat strobes and link state, and drives the three QSFP-cage LEDs. It also keeps saturating correctable/uncorrectable error counts for debug readout. All timing is derived from a programmable millisecond-scale tick.

## Interface
- TICK_DIV, 250000, clk cycles per tick (1 ms at 250 MHz); ≥2
- ACT_HOLD_TICKS, 50, ticks activity indication persists after last beat
- BLINK_TICKS, 250, ticks per blink half-period
- ERR_HOLD_TICKS, 1000, ticks a correctable-error warning persists
- CNT_WIDTH, 16, error counter width
- clk  in  1  core clock, 250 MHz
- rst_n  in  1  asynchronous, active-low reset
- link_up  in  1  PCIe user link up, level
- rq_beat  in  1  RQ tvalid&tready strobe
- rc_beat  in  1  RC tvalid&tready strobe
- status_error_cor  in  1  correctable-error pulse from core
- status_error_uncor  in  1  uncorrectable-error pulse from core
- clear  in  1  single-cycle pulse: zero counters, release fault
- qsfp_led_act  out  1  activity LED, active-high
- qsfp_led_stat_g  out  1  green status LED, active-high
- qsfp_led_stat_y  out  1  yellow status LED, active-high
- err_cor_count  out  CNT_WIDTH  saturating correctable count
- err_uncor_count  out  CNT_WIDTH  saturating uncorrectable count
- fault  out  1  sticky uncorrectable-error flag

## Operation
- Tick: counter 0..TICK_DIV-1, tick=1 for one cycle when counter==TICK_DIV-1, then wraps to 0.
- Blink phase: free-running tick counter; phase toggles every BLINK_TICKS ticks.
- Activity: any beat (rq_beat|rc_beat) loads act_timer=ACT_HOLD_TICKS; decrements by 1 per tick, stops at 0. A beat in a tick cycle reloads (load wins).
- qsfp_led_act: 0 if !link_up; phase if act_timer≠0; else 1 (solid on idle link, blinking when busy).
- Status FSM states: LINK_DOWN, OK, COR_WARN, UNCOR_FAULT. Event priority: uncor > clear > !link_up > cor > timer expiry.
  - any state, uncor → UNCOR_FAULT (even with clear same cycle).
  - UNCOR_FAULT: leaves only on clear → LINK_DOWN if !link_up, else OK. Link loss does not exit.
  - LINK_DOWN → OK when link_up.
  - OK/COR_WARN, !link_up → LINK_DOWN.
  - OK, cor → COR_WARN, err_timer=ERR_HOLD_TICKS; COR_WARN, cor → reload err_timer.
  - COR_WARN → OK when err_timer==1 and tick.
- LEDs per state: LINK_DOWN g=0 y=0; OK g=1 y=0; COR_WARN g=1 y=1; UNCOR_FAULT g=0 y=phase.
- fault=1 exactly in UNCOR_FAULT.
- Counters: +1 per pulse, saturate at all-ones. On clear: count ← (pulse same cycle ? 1 : 0).

## Timing
- Reset: all outputs 0, state LINK_DOWN, all timers/counters 0, phase 0.
- All outputs registered; input sampled at edge N is reflected on outputs after edge N+1 (one-cycle latency).
- Inputs are synchronous to clk, no synchronizers; strobes may be asserted on consecutive cycles, each counted.
- Reset assertion mid-operation clears everything asynchronously; release synchronous to clk via existing reset sync upstream.
- Tick counter width clog2(TICK_DIV); timer widths clog2(max hold+1).

## Structure
- Shared package dma_bench_status_pkg: state encodings (LINK_DOWN=0, OK=1, COR_WARN=2, UNCOR_FAULT=3) and the LED-per-state mapping constants.
- One sub-module: led_tick_gen (prescaler + blink phase; params TICK_DIV, BLINK_TICKS; outputs tick, phase).
- FSM, timers, counters, output registers in pcie_status_led.

## Test plan
Bench params: TICK_DIV=4, ACT_HOLD_TICKS=3, BLINK_TICKS=2, ERR_HOLD_TICKS=5, CNT_WIDTH=4.
- Reset, link_up=0 → all outputs 0; raise link_up → cycle after sampling g=1, act=1, y=0.
- One rq_beat → act follows phase (toggles every 8 cycles) for 3 ticks, then solid 1.
- cor pulse → g=1 y=1, err_cor_count=1; returns to y=0 after 5 ticks; second cor at tick 3 extends to 5 ticks from reload.
- 17 cor pulses back-to-back → err_cor_count saturates at 15.
- uncor pulse, then drop link_up → fault=1, g=0, y blinks; clear with link_up=0 → LINK_DOWN, fault=0, counts 0.
- clear and uncor same cycle → stays UNCOR_FAULT, err_uncor_count=1.
